// File: rtl/lsu_bus_adapter_if.sv
// Data-bus interface between the load/store unit and external memory.
// One valid/ready request channel (address, write enable, byte enables,
// write data) and a response channel (valid plus read data). For writes,
// the response valid is the write acknowledge.
//   master: drives the request channel (the LSU adapter).
//   slave : drives ready and the response channel (memory or interconnect).
interface lsu_bus_adapter_if #(
  parameter int unsigned WIDTH_DATA = 32,
  parameter int unsigned WIDTH_ADDR = 32
);
  logic                  bus_req_valid;
  logic                  bus_req_ready;
  logic [WIDTH_ADDR-1:0] bus_addr;
  logic                  bus_we;
  logic [3:0]            bus_be;
  logic [WIDTH_DATA-1:0] bus_wdata;
  logic                  bus_rsp_valid;
  logic [WIDTH_DATA-1:0] bus_rsp_data;

  modport master (
    output bus_req_valid, bus_addr, bus_we, bus_be, bus_wdata,
    input  bus_req_ready, bus_rsp_valid, bus_rsp_data
  );

  modport slave (
    input  bus_req_valid, bus_addr, bus_we, bus_be, bus_wdata,
    output bus_req_ready, bus_rsp_valid, bus_rsp_data
  );
endinterface

// File: rtl/lsu_bus_adapter.sv
// Multi-cycle load/store unit placed after the EX/MEM register. It turns one
// MEM-stage load or store into a single valid/ready bus transaction. It stalls
// the pipeline until the access completes, and returns aligned, extended load
// data.
//   clk, rst_n       : clock, asynchronous active-low reset
//   M_MemRead/Write  : MEM-stage load/store request (store wins if both are set)
//   M_funct3         : access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   M_addr, M_wdata  : byte address, right-aligned store data
//   lsu_rdata        : extended load result, held until the next load completes
//   lsu_stall        : hold the F/D/E/M stages
//   lsu_misalign     : one-cycle pulse when an access is rejected as misaligned
//   lsu_timeout      : one-cycle pulse when an access is aborted for no response
//   bus              : request/response data bus (master side)
// Only WIDTH_DATA == 32 is supported.
module lsu_bus_adapter #(
  parameter int unsigned WIDTH_DATA     = 32,
  parameter int unsigned WIDTH_ADDR     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  M_MemRead,
  input  logic                  M_MemWrite,
  input  logic [2:0]            M_funct3,
  input  logic [WIDTH_ADDR-1:0] M_addr,
  input  logic [WIDTH_DATA-1:0] M_wdata,
  output logic [WIDTH_DATA-1:0] lsu_rdata,
  output logic                  lsu_stall,
  output logic                  lsu_misalign,
  output logic                  lsu_timeout,
  lsu_bus_adapter_if.master     bus
);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                  resp_timeout;

  logic [WIDTH_ADDR-1:0] addr_q;
  logic [2:0]            funct3_q;
  logic                  we_q;
  logic [3:0]            be_q, be_in;
  logic [WIDTH_DATA-1:0] wdata_q, wdata_in;
  logic [WIDTH_DATA-1:0] rdata_q, load_val;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;

  logic                  req, misaligned, accept, req_valid;
  logic [1:0]            off;

  // Request decode. funct3[1:0]: 00 byte, 01 half, 1x word.
  assign req        = M_MemRead | M_MemWrite;
  assign off        = M_addr[1:0];
  assign misaligned = (M_funct3[1:0] == 2'b01) ? off[0] :
                      (M_funct3[1] ? (off != 2'b00) : 1'b0);

  // Store lane placement; loads always fetch the whole word.
  always_comb begin
    be_in    = 4'b1111;
    wdata_in = '0;
    if (M_MemWrite) begin
      case (M_funct3[1:0])
        2'b00: begin
          be_in    = 4'b0001 << off;
          wdata_in = {4{M_wdata[7:0]}};
        end
        2'b01: begin
          be_in    = off[1] ? 4'b1100 : 4'b0011;
          wdata_in = {2{M_wdata[15:0]}};
        end
        default: wdata_in = M_wdata;
      endcase
    end
  end

  // Load lane extraction from the response word.
  always_comb begin
    load_byte = bus.bus_rsp_data[{addr_q[1:0], 3'b000} +: 8];
    load_half = addr_q[1] ? bus.bus_rsp_data[31:16] : bus.bus_rsp_data[15:0];
    case (funct3_q)
      3'b000:  load_val = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_val = {{16{load_half[15]}}, load_half};
      3'b100:  load_val = {24'h0, load_byte};
      3'b101:  load_val = {16'h0, load_half};
      default: load_val = bus.bus_rsp_data;
    endcase
  end

  assign cnt_inc      = cnt_q + CntW'(1);
  assign resp_timeout = (cnt_inc == CntMax);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StReq;
      StReq: begin
        if (bus.bus_req_ready) begin
          state_d = StResp;
          cnt_d   = '0;
        end
      end
      StResp: begin
        if (bus.bus_rsp_valid) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_inc;
          if (resp_timeout) state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
    endcase
  end

  // FSM: outputs. Gating with rst_n keeps stall/misalign low while reset is
  // held even if the pipeline still presents a request.
  always_comb begin
    accept       = 1'b0;
    lsu_stall    = 1'b0;
    lsu_misalign = 1'b0;
    lsu_timeout  = 1'b0;
    req_valid    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rst_n && req) begin
          if (misaligned) begin
            lsu_misalign = 1'b1;
          end else begin
            accept    = 1'b1;
            lsu_stall = 1'b1;
          end
        end
      end
      StReq: begin
        req_valid = 1'b1;
        lsu_stall = 1'b1;
      end
      StResp: lsu_stall = 1'b1;
      // The counter only reaches the limit on the timeout path.
      StDone: lsu_timeout = (cnt_q == CntMax);
    endcase
  end

  // Request capture and load result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        addr_q   <= M_addr;
        funct3_q <= M_funct3;
        we_q     <= M_MemWrite;
        be_q     <= be_in;
        wdata_q  <= wdata_in;
      end
      if (state_q == StResp) begin
        if (bus.bus_rsp_valid) begin
          if (!we_q) rdata_q <= load_val;
        end else if (resp_timeout) begin
          rdata_q <= '0;
        end
      end
    end
  end

  assign bus.bus_req_valid = req_valid;
  assign bus.bus_addr      = {addr_q[WIDTH_ADDR-1:2], 2'b00};
  assign bus.bus_we        = we_q;
  assign bus.bus_be        = be_q;
  assign bus.bus_wdata     = wdata_q;

  assign lsu_rdata = lsu_misalign ? '0 : rdata_q;

endmodule

// File: tb/tb_lsu_bus_adapter.sv
module tb_lsu_bus_adapter;
  localparam int unsigned TO = 16;

  logic        clk;
  logic        rst_n;
  logic        M_MemRead, M_MemWrite;
  logic [2:0]  M_funct3;
  logic [31:0] M_addr, M_wdata;
  logic [31:0] lsu_rdata;
  logic        lsu_stall, lsu_misalign, lsu_timeout;

  lsu_bus_adapter_if #(.WIDTH_DATA(32), .WIDTH_ADDR(32)) bus ();

  lsu_bus_adapter #(.WIDTH_DATA(32), .WIDTH_ADDR(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .M_MemRead   (M_MemRead),
    .M_MemWrite  (M_MemWrite),
    .M_funct3    (M_funct3),
    .M_addr      (M_addr),
    .M_wdata     (M_wdata),
    .lsu_rdata   (lsu_rdata),
    .lsu_stall   (lsu_stall),
    .lsu_misalign(lsu_misalign),
    .lsu_timeout (lsu_timeout),
    .bus         (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        stall, mis, tmo, vld, chk_bus, wchk, we;
    logic [31:0] rdata, addr, wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0, errors = 0;
  int          stall_cnt = 0, mis_cnt = 0, tmo_cnt = 0, hs_cnt = 0;
  int          cfg_rdy_wait = 0, cfg_rsp_wait = 0;
  bit          cfg_never = 0;
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_be;
  logic [31:0] model_rdata;
  logic [31:0] model_mem[256];
  logic [31:0] bus_mem[256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic stall, input logic mis, input logic tmo,
                              input logic vld, input logic [31:0] rdata);
    exp_t e;
    e       = '0;
    e.stall = stall;
    e.mis   = mis;
    e.tmo   = tmo;
    e.vld   = vld;
    e.rdata = rdata;
    return e;
  endfunction

  function automatic exp_t rst_exp();
    exp_t e;
    e         = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    e.chk_bus = 1'b1;
    e.wchk    = 1'b1;
    return e;
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // Reference load: shift the addressed bytes down, keep n bytes, extend.
  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] word);
    int          n;
    logic [31:0] v, mask;
    n = size_of(f3);
    v = word >> (8 * (a % 4));
    if (n == 4) return v;
    mask = (32'h1 << (8 * n)) - 32'h1;
    v    = v & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // Compare process: one expectation per cycle, sampled mid-cycle.
  initial begin : compare
    exp_t e;
    forever begin
      @(negedge clk);
      if (lsu_stall) stall_cnt++;
      if (lsu_misalign) mis_cnt++;
      if (lsu_timeout) tmo_cnt++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("lsu_stall", 32'(lsu_stall), 32'(e.stall));
        chk("lsu_misalign", 32'(lsu_misalign), 32'(e.mis));
        chk("lsu_timeout", 32'(lsu_timeout), 32'(e.tmo));
        chk("bus_req_valid", 32'(bus.bus_req_valid), 32'(e.vld));
        chk("lsu_rdata", lsu_rdata, e.rdata);
        if (e.chk_bus) begin
          chk("bus_addr", bus.bus_addr, e.addr);
          chk("bus_we", 32'(bus.bus_we), 32'(e.we));
          chk("bus_be", 32'(bus.bus_be), 32'(e.be));
        end
        if (e.wchk) chk("bus_wdata", bus.bus_wdata, e.wdata);
      end
    end
  end

  // Memory-side responder: ready after cfg_rdy_wait cycles of valid, response
  // cfg_rsp_wait cycles after the first RESP cycle, or never.
  initial begin : responder
    int          vcnt, rcnt;
    bit          pend, pwe;
    logic [31:0] pa;
    vcnt = 0; rcnt = 0; pend = 0; pwe = 0; pa = '0;
    bus.bus_req_ready = 1'b0;
    bus.bus_rsp_valid = 1'b0;
    bus.bus_rsp_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.bus_req_ready && rst_n && !cfg_never) begin
        pend = 1; rcnt = 0;
      end
      bus.bus_req_ready = 1'b0;
      bus.bus_rsp_valid = 1'b0;
      bus.bus_rsp_data  = '0;
      if (!rst_n) begin
        pend = 0; vcnt = 0;
      end else if (pend) begin
        if (rcnt == cfg_rsp_wait) begin
          bus.bus_rsp_valid = 1'b1;
          bus.bus_rsp_data  = pwe ? 32'hDEAD_BEEF : bus_mem[pa[9:2]];
          pend = 0;
        end else begin
          rcnt++;
        end
      end else if (bus.bus_req_valid) begin
        if (vcnt >= cfg_rdy_wait) begin
          bus.bus_req_ready = 1'b1;
          vcnt       = 0;
          hs_cnt++;
          pa         = bus.bus_addr;
          pwe        = bus.bus_we;
          last_addr  = bus.bus_addr;
          last_be    = bus.bus_be;
          last_wdata = bus.bus_wdata;
          if (bus.bus_we)
            for (int i = 0; i < 4; i++)
              if (bus.bus_be[i]) bus_mem[pa[9:2]][8*i +: 8] = bus.bus_wdata[8*i +: 8];
        end else begin
          vcnt++;
        end
      end
    end
  end

  task automatic step(input exp_t e);
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    M_MemRead  = 1'b0;
    M_MemWrite = 1'b0;
    repeat (n) step(mk(1'b0, 1'b0, 1'b0, 1'b0, model_rdata));
  endtask

  function automatic exp_t req_exp(input bit st, input logic [31:0] a, input int n,
                                   input logic [31:0] wd);
    exp_t e;
    e         = mk(1'b1, 1'b0, 1'b0, 1'b1, model_rdata);
    e.chk_bus = 1'b1;
    e.addr    = a & ~32'h3;
    e.we      = st;
    e.be      = st ? 4'(((1 << n) - 1) << (a % 4)) : 4'hF;
    e.wchk    = st;
    case (n)
      1:       e.wdata = {24'h0, wd[7:0]} * 32'h0101_0101;
      2:       e.wdata = {16'h0, wd[15:0]} * 32'h0001_0001;
      default: e.wdata = wd;
    endcase
    return e;
  endfunction

  task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int rdy, input int rspw, input bit never);
    int          n, resp_cycles;
    logic [31:0] result, b;
    cfg_rdy_wait = rdy; cfg_rsp_wait = rspw; cfg_never = never;
    M_MemRead = !st; M_MemWrite = st; M_funct3 = f3; M_addr = a; M_wdata = wd;
    n = size_of(f3);
    if ((a % n) != 0) begin
      step(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
      return;
    end
    result      = load_model(f3, a, model_mem[a[9:2]]);
    resp_cycles = never ? TO : rspw + 1;
    step(mk(1'b1, 1'b0, 1'b0, 1'b0, model_rdata));
    repeat (rdy + 1) step(req_exp(st, a, n, wd));
    repeat (resp_cycles) step(mk(1'b1, 1'b0, 1'b0, 1'b0, model_rdata));
    if (never) model_rdata = 32'h0;
    else if (!st) model_rdata = result;
    if (st && !never)
      for (int k = 0; k < n; k++) begin
        b = a + 32'(k);
        model_mem[b[9:2]][8*b[1:0] +: 8] = wd[8*k +: 8];
      end
    step(mk(1'b0, 1'b0, never, 1'b0, model_rdata));
  endtask

  initial begin : driver
    int s0, h0, m0, t0;
    rst_n = 1'b0;
    M_MemRead = 1'b0; M_MemWrite = 1'b0; M_funct3 = '0; M_addr = '0; M_wdata = '0;
    model_rdata = '0;
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = '0;
      bus_mem[i]   = '0;
    end
    model_mem[64] = 32'h80FF_1234; bus_mem[64] = 32'h80FF_1234;   // 0x100
    model_mem[128] = 32'h5566_7788; bus_mem[128] = 32'h5566_7788; // 0x200
    model_mem[4] = 32'h1122_3344; bus_mem[4] = 32'h1122_3344;     // 0x10
    model_mem[8] = 32'hCAFE_F00D; bus_mem[8] = 32'hCAFE_F00D;     // 0x20
    @(posedge clk); #1;
    step(rst_exp());
    step(rst_exp());
    rst_n = 1'b1;
    idle(2);

    // LB 0x103, zero-wait bus
    s0 = stall_cnt;
    access(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 1'b0);
    idle(1);
    chk("lb_rdata_lit", lsu_rdata, 32'hFFFF_FF80);
    chk("lb_stall_cycles", 32'(stall_cnt - s0), 32'd3);
    chk("lb_bus_addr", last_addr, 32'h100);
    chk("lb_bus_be", 32'(last_be), 32'hF);

    // SH 0xABCD to 0x202, ready low for 2 cycles
    s0 = stall_cnt;
    access(1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 2, 0, 1'b0);
    idle(1);
    chk("sh_bus_be", 32'(last_be), 32'hC);
    chk("sh_bus_wdata", last_wdata, 32'hABCD_ABCD);
    chk("sh_stall_cycles", 32'(stall_cnt - s0), 32'd5);
    chk("sh_rdata_held", lsu_rdata, 32'hFFFF_FF80);

    // LHU 0x101: misaligned
    s0 = stall_cnt; h0 = hs_cnt; m0 = mis_cnt;
    access(1'b0, 3'b101, 32'h101, 32'h0, 0, 0, 1'b0);
    idle(1);
    chk("mis_pulses", 32'(mis_cnt - m0), 32'd1);
    chk("mis_handshakes", 32'(hs_cnt - h0), 32'd0);
    chk("mis_stall_cycles", 32'(stall_cnt - s0), 32'd0);

    // LH 0x202 reads back the stored half
    access(1'b0, 3'b001, 32'h202, 32'h0, 0, 1, 1'b0);
    idle(1);
    chk("lh_rdata_lit", lsu_rdata, 32'hFFFF_ABCD);

    // LW with no response
    s0 = stall_cnt; t0 = tmo_cnt;
    access(1'b0, 3'b010, 32'h20, 32'h0, 0, 0, 1'b1);
    idle(1);
    chk("tmo_pulses", 32'(tmo_cnt - t0), 32'd1);
    chk("tmo_stall_cycles", 32'(stall_cnt - s0), 32'd18);
    chk("tmo_rdata", lsu_rdata, 32'h0);

    // LBU 0x102, slow response
    access(1'b0, 3'b100, 32'h102, 32'h0, 1, 3, 1'b0);
    idle(1);
    chk("lbu_rdata_lit", lsu_rdata, 32'h0000_00FF);

    // Reset during RESP of an LW; request stays visible through reset
    h0 = hs_cnt;
    cfg_rdy_wait = 0; cfg_rsp_wait = 0; cfg_never = 1'b1;
    M_MemRead = 1'b1; M_MemWrite = 1'b0; M_funct3 = 3'b010; M_addr = 32'h10; M_wdata = '0;
    step(mk(1'b1, 1'b0, 1'b0, 1'b0, model_rdata));
    step(req_exp(1'b0, 32'h10, 4, 32'h0));
    step(mk(1'b1, 1'b0, 1'b0, 1'b0, model_rdata));
    step(mk(1'b1, 1'b0, 1'b0, 1'b0, model_rdata));
    exp_q.push_back(rst_exp());
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    model_rdata = 32'h0;
    step(rst_exp());
    rst_n = 1'b1;
    idle(3);
    chk("rst_no_retry", 32'(hs_cnt - h0), 32'd1);
    access(1'b0, 3'b010, 32'h10, 32'h0, 0, 0, 1'b0);
    idle(1);
    chk("post_rst_lw_lit", lsu_rdata, 32'h1122_3344);

    // LW 0x10 then SW 0x14 back-to-back
    h0 = hs_cnt;
    access(1'b0, 3'b010, 32'h10, 32'h0, 0, 0, 1'b0);
    access(1'b1, 3'b010, 32'h14, 32'h1357_9BDF, 0, 0, 1'b0);
    idle(2);
    chk("b2b_handshakes", 32'(hs_cnt - h0), 32'd2);
    chk("b2b_sw_addr", last_addr, 32'h14);
    chk("b2b_sw_wdata", last_wdata, 32'h1357_9BDF);
    access(1'b0, 3'b010, 32'h14, 32'h0, 0, 0, 1'b0);
    idle(1);
    chk("sw_readback_lit", lsu_rdata, 32'h1357_9BDF);

    // SB 0x5A to 0x21, then LB 0x21 and LW 0x20
    access(1'b1, 3'b000, 32'h21, 32'h0000_005A, 1, 2, 1'b0);
    idle(1);
    chk("sb_bus_be", 32'(last_be), 32'h2);
    chk("sb_bus_wdata", last_wdata, 32'h5A5A_5A5A);
    access(1'b0, 3'b000, 32'h21, 32'h0, 0, 0, 1'b0);
    access(1'b0, 3'b010, 32'h20, 32'h0, 0, 0, 1'b0);
    idle(2);
    chk("sb_word_lit", lsu_rdata, 32'hCAFE_5A0D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
